// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and digit slicing for the seven-segment scan driver
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;
  function automatic logic [6:0] digit_slice(input logic [27:0] segs, input logic [1:0] idx);
    return segs[7*idx +: 7];
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: slot counter and digit index; flags the frame boundary (last slot of digit 3)
module scan_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic                        clk_in,
  input  logic                        RESET,
  output logic [$clog2(SCAN_DIV)-1:0] cnt,
  output logic [1:0]                  idx,
  output logic                        frame
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic tick;
  always_comb begin
    tick = cnt_q == LAST;
    frame = tick && idx_q == 2'd3;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = tick ? idx_q + 1'b1 : idx_q;
  end
  // Reset parks on the last cycle of digit 3 so the first edge is a frame boundary
  always_ff @(posedge clk_in or posedge RESET)
    if (RESET) begin
      cnt_q <= LAST;
      idx_q <= 2'd3;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  assign cnt = cnt_q;
  assign idx = idx_q;
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: frame-snapshotted four-digit multiplexed display driver with guard, blank and flash
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 500,
  parameter int FLASH_FRAMES = 64
) (
  input  logic        clk_in,
  input  logic        RESET,
  input  logic [27:0] seg_in,
  input  logic [3:0]  dp_in,
  input  logic        blank,
  input  logic        flash_en,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  an_out,
  output logic        frame_tick
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = FLASH_FRAMES > 1 ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FW-1:0] FLAST = FW'(FLASH_FRAMES - 1);
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic frame, dark;
  logic [27:0] snap_seg_q, snap_seg_d;
  logic [3:0] snap_dp_q, snap_dp_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic ph_q, ph_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  logic [3:0] an_q, an_d;
  logic frame_tick_q, frame_tick_d;
  scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_pre (
    .clk_in (clk_in),
    .RESET  (RESET),
    .cnt    (cnt),
    .idx    (idx),
    .frame  (frame)
  );
  always_comb begin
    snap_seg_d = frame ? seg_in : snap_seg_q;
    snap_dp_d = frame ? dp_in : snap_dp_q;
    fcnt_d = !flash_en ? '0 : !frame ? fcnt_q : fcnt_q == FLAST ? '0 : fcnt_q + 1'b1;
    ph_d = !flash_en ? 1'b1 : (frame && fcnt_q == FLAST) ? ~ph_q : ph_q;
    dark = blank | (flash_en & ~ph_q) | (cnt < CW'(GUARD));
    seg_d = dark ? SEG_OFF : digit_slice(snap_seg_q, idx);
    dp_d = dark | ~snap_dp_q[idx];
    an_d = dark ? AN_OFF : ~(4'b0001 << idx);
    frame_tick_d = frame;
  end
  always_ff @(posedge clk_in or posedge RESET)
    if (RESET) begin
      snap_seg_q <= '1;
      snap_dp_q <= '0;
      fcnt_q <= '0;
      ph_q <= 1'b1;
      seg_q <= SEG_OFF;
      dp_q <= 1'b1;
      an_q <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      snap_seg_q <= snap_seg_d;
      snap_dp_q <= snap_dp_d;
      fcnt_q <= fcnt_d;
      ph_q <= ph_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_q <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  assign seg_out = seg_q;
  assign dp_out = dp_q;
  assign an_out = an_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized stimulus against a frame-position model plus directed literal checks
module tb_seg7_scan_driver;
  localparam int SD = 4;
  localparam int G = 1;
  localparam int FF = 2;
  localparam int FRAME = 4 * SD;
  logic clk_in = 1'b0;
  logic RESET = 1'b0;
  logic [27:0] seg_in = 28'h0123456;
  logic [3:0] dp_in = 4'b0100;
  logic blank = 1'b0;
  logic flash_en = 1'b0;
  logic [6:0] seg_out;
  logic dp_out;
  logic [3:0] an_out;
  logic frame_tick;
  int errs = 0;
  int checks = 0;
  bit started = 0;
  seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(G), .FLASH_FRAMES(FF)) dut (
    .clk_in     (clk_in),
    .RESET      (RESET),
    .seg_in     (seg_in),
    .dp_in      (dp_in),
    .blank      (blank),
    .flash_en   (flash_en),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask
  // Model: n is the cycle position inside a frame, fr counts frames since flash_en rose
  int n, fr, c, d;
  logic [27:0] m_seg;
  logic [3:0] m_dp;
  logic [6:0] e_seg;
  logic e_dp, e_ft, dk, vis;
  logic [3:0] e_an;
  always @(posedge clk_in or posedge RESET)
    if (RESET) begin
      n = FRAME - 1; fr = 0; m_seg = '1; m_dp = '0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ft = 1'b0;
    end else begin
      c = n % SD;
      d = n / SD;
      vis = ((fr / FF) % 2) == 0;
      dk = blank | (flash_en & ~vis) | (c < G);
      e_seg = dk ? 7'h7F : 7'((m_seg >> (7 * d)) & 28'h7F);
      e_dp = dk ? 1'b1 : ~m_dp[d];
      e_an = dk ? 4'hF : ~(4'b0001 << d);
      e_ft = n == FRAME - 1;
      if (n == FRAME - 1) begin
        m_seg = seg_in;
        m_dp = dp_in;
        if (flash_en) fr++;
      end
      if (!flash_en) fr = 0;
      n = (n + 1) % FRAME;
    end
  always @(negedge clk_in)
    if (started) begin
      chk("seg", 32'(seg_out), 32'(e_seg));
      chk("dp", 32'(dp_out), 32'(e_dp));
      chk("an", 32'(an_out), 32'(e_an));
      chk("ft", 32'(frame_tick), 32'(e_ft));
    end
  task automatic step(input int k);
    repeat (k) @(negedge clk_in);
  endtask
  task automatic wait_ft(input string nm);
    int k = 0;
    while (!frame_tick && k < 100) begin
      step(1);
      k++;
    end
    chk(nm, 32'(k < 100), 32'd1);
  endtask
  initial begin
    #1 RESET = 1'b1;
    step(2);
    started = 1;
    RESET = 1'b0;
    step(1);
    chk("lit_ft1", 32'(frame_tick), 32'd1);
    chk("lit_seg1", 32'(seg_out), 32'h7F);
    step(1);
    chk("lit_an2", 32'(an_out), 32'hF);
    chk("lit_ft2", 32'(frame_tick), 32'd0);
    step(1);
    chk("lit_an3", 32'(an_out), 32'hE);
    chk("lit_seg3", 32'(seg_out), 32'h56);
    chk("lit_dp3", 32'(dp_out), 32'd1);
    step(2);
    chk("lit_an5", 32'(an_out), 32'hE);
    step(1);
    chk("lit_an6", 32'(an_out), 32'hF);
    step(1);
    chk("lit_an7", 32'(an_out), 32'hD);
    chk("lit_seg7", 32'(seg_out), 32'h68);
    step(4);
    chk("lit_an11", 32'(an_out), 32'hB);
    chk("lit_dp11", 32'(dp_out), 32'd0);
    chk("lit_seg11", 32'(seg_out), 32'h48);
    seg_in = 28'h7654321;
    step(4);
    chk("hold_an15", 32'(an_out), 32'h7);
    chk("hold_seg15", 32'(seg_out), 32'h00);
    step(4);
    chk("new_an19", 32'(an_out), 32'hE);
    chk("new_seg19", 32'(seg_out), 32'h21);
    blank = 1'b1;
    step(1);
    chk("blank_an20", 32'(an_out), 32'hF);
    step(2);
    blank = 1'b0;
    step(1);
    chk("blank_an23", 32'(an_out), 32'hD);
    flash_en = 1'b1;
    wait_ft("flash_wait1");
    step(1);
    wait_ft("flash_wait2");
    step(2);
    for (int i = 0; i < 8; i++) begin
      chk("flash_dark", 32'(an_out), 32'hF);
      step(1);
    end
    flash_en = 1'b0;
    step(3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 4 == 0) seg_in = 28'($urandom);
      if ($urandom % 8 == 0) dp_in = 4'($urandom);
      blank = ($urandom % 16) == 0;
      if ($urandom % 100 == 0) flash_en = ~flash_en;
      step(1);
    end
    #2 RESET = 1'b1;
    #1;
    chk("rst_an", 32'(an_out), 32'hF);
    chk("rst_seg", 32'(seg_out), 32'h7F);
    chk("rst_dp", 32'(dp_out), 32'd1);
    chk("rst_ft", 32'(frame_tick), 32'd0);
    step(2);
    RESET = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom % 4 == 0) seg_in = 28'($urandom);
      blank = ($urandom % 16) == 0;
      step(1);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
